sparrow_mem_arbiter: RTL and testbench
======================================

SPARROW_MEM_ARBITER -- requirements
Module: sparrow_mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_DSTREAK, default 4: the maximum number of consecutive data grants while a fetch is pending.
REQ-002 SHALL use a single clock and a synchronous, active-high reset.
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
REQ-003 SHALL have the instruction-fetch port:
- imem_req_i  in  1  fetch request
- imem_addr_i  in  32  fetch address
- imem_gnt_o  out  1  fetch accepted
- imem_rvalid_o  out  1  fetch data valid
- imem_rdata_o  out  32  fetch data
REQ-004 SHALL have the data port:
- dmem_req_i  in  1  data request
- dmem_wr_en_i  in  1  store when 1
- dmem_byte_en_i  in  2  access size as mem_access_size_e (BYTE=00, HALF_WORD=01, WORD=11)
- dmem_addr_i  in  32  data address
- dmem_wdata_i  in  32  store data, right-aligned
- dmem_gnt_o  out  1  data request accepted
- dmem_rvalid_o  out  1  data response valid
- dmem_rdata_o  out  32  load data
- dmem_err_o  out  1  misaligned-access pulse
REQ-005 SHALL have the shared bus port:
- bus_req_o  out  1  bus request
- bus_we_o  out  1  bus write
- bus_be_o  out  4  byte lane enables
- bus_addr_o  out  32  bus address
- bus_wdata_o  out  32  bus write data
- bus_gnt_i  in  1  bus accepts request
- bus_rvalid_i  in  1  bus response valid, for reads and writes
- bus_rdata_i  in  32  bus read data

Function
REQ-006 SHALL implement three states: IDLE, REQ (request presented, owner locked) and RESP (awaiting bus_rvalid_i); at most one transaction SHALL be outstanding.
REQ-007 In IDLE, a requesting port SHALL be selected combinationally with data priority, except that fetch SHALL win when imem_req_i=1 and streak=MAX_DSTREAK.
REQ-008 Streak counter: SHALL increment on each data grant while imem_req_i=1, saturating at MAX_DSTREAK; SHALL clear on a fetch grant or any cycle with imem_req_i=0.
REQ-009 In IDLE with a selection, bus_req_o SHALL be 1 in the same cycle; bus_gnt_i=1 SHALL go to RESP, otherwise to REQ.
REQ-010 In REQ, the owner and bus attributes SHALL stay frozen until bus_gnt_i, then go to RESP; the requester SHALL hold its req and attributes until it sees its gnt.
REQ-011 The owner's gnt output SHALL equal bus_req_o & bus_gnt_i; the other port's gnt SHALL be 0.
REQ-012 In RESP, bus_req_o SHALL be 0; on bus_rvalid_i, the arbiter SHALL drive the owner's rvalid=1 and rdata=bus_rdata_i for one cycle, then return to IDLE; the earliest next bus_req_o is the following cycle.
REQ-013 The non-owner's rvalid SHALL be 0; both rdata outputs SHALL be valid only when their rvalid=1.
REQ-014 A fetch SHALL drive bus_we_o=0, bus_be_o=1111 and bus_addr_o={imem_addr_i[31:2],2'b00}.
REQ-015 Data byte enables: BYTE -> 0001<<addr[1:0]; HALF_WORD -> 0011<<addr[1:0]; WORD -> 1111. bus_addr_o SHALL be {addr[31:2],2'b00}.
REQ-016 Data write data: BYTE SHALL replicate wdata[7:0] x4; HALF_WORD SHALL replicate wdata[15:0] x2; WORD SHALL pass through unchanged.
REQ-017 A misaligned data request (HALF_WORD with addr[0]=1, WORD with addr[1:0]!=0, or size 10) seen in IDLE SHALL take priority and get dmem_gnt_o=1 and dmem_err_o=1 in the same cycle. It SHALL NOT raise bus_req_o or grant fetch that cycle, and the arbiter SHALL stay in IDLE with the streak unchanged.
REQ-018 bus_rvalid_i in IDLE or REQ SHALL be ignored: no rvalid on either port.

Reset
REQ-019 While rst=1, the arbiter SHALL enter IDLE, clear the streak and owner, and drive all gnt, rvalid, err and bus_req_o outputs to 0, including during REQ or RESP; an in-flight response is dropped.
REQ-020 After rst, all data outputs (rdata, addr, wdata, be, we) SHALL be 0.

Verification
REQ-021 Fetch only: imem_req_i=1, addr 0x104, bus_gnt_i=1 at once, bus_rvalid_i 2 cycles later with 0xDEADBEEF -> bus_addr_o=0x104, be=1111, imem_gnt_o pulses in cycle 0, imem_rvalid_o=1 with 0xDEADBEEF.
REQ-022 Byte store: SB addr 0x203, wdata 0x000000AB -> bus_be_o=1000, bus_wdata_o=0xABABABAB, bus_we_o=1, dmem_rvalid_o on bus response.
REQ-023 Starvation guard: both ports request continuously, MAX_DSTREAK=4 -> grant order D,D,D,D,I,D,...
REQ-024 Misaligned LW addr 0x102 -> dmem_gnt_o=dmem_err_o=1 for one cycle, bus_req_o stays 0; a pending fetch is granted the next cycle.
REQ-025 Bus stall: bus_gnt_i=0 for 3 cycles during a fetch, dmem_req_i rises mid-stall -> owner stays fetch, attributes stable, data granted after the fetch response.
REQ-026 Reset in RESP, then bus_rvalid_i -> no rvalid on either port, and all outputs 0 during rst.

Source files
------------

// File: rtl/sparrow_mem_arbiter.sv
// Shares one memory bus between an instruction-fetch port and a data port.
// Data has priority, but a streak limit guarantees a pending fetch eventually wins.
module sparrow_mem_arbiter #(
    parameter int unsigned MAX_DSTREAK = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        imem_req_i,
    input  logic [31:0] imem_addr_i,
    output logic        imem_gnt_o,
    output logic        imem_rvalid_o,
    output logic [31:0] imem_rdata_o,

    input  logic        dmem_req_i,
    input  logic        dmem_wr_en_i,
    input  logic [1:0]  dmem_byte_en_i,
    input  logic [31:0] dmem_addr_i,
    input  logic [31:0] dmem_wdata_i,
    output logic        dmem_gnt_o,
    output logic        dmem_rvalid_o,
    output logic [31:0] dmem_rdata_o,
    output logic        dmem_err_o,

    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i
);

    typedef enum logic [1:0] {
        BYTE      = 2'b00,
        HALF_WORD = 2'b01,
        WORD      = 2'b11
    } mem_access_size_e;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StResp
    } state_e;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_attr_t;

    localparam int unsigned StreakW = (MAX_DSTREAK < 1) ? 1 : $clog2(MAX_DSTREAK + 1);
    localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_DSTREAK);

    state_e             state_q, state_d;
    logic               owner_fetch_q, owner_fetch_d;
    logic [StreakW-1:0] streak_q, streak_d;
    bus_attr_t          attr_q, attr_d;
    bus_attr_t          fetch_attr, data_attr;

    logic d_misaligned;
    logic idle_err, idle_fetch, idle_data, streak_full;
    logic bus_req, cur_fetch, bus_take, resp, err;

    // Fetches are always word accesses, so the low address bits are don't-care.
    logic unused_imem_addr;
    assign unused_imem_addr = ^imem_addr_i[1:0];

    always_comb begin
        fetch_attr.we    = 1'b0;
        fetch_attr.be    = 4'b1111;
        fetch_attr.addr  = {imem_addr_i[31:2], 2'b00};
        fetch_attr.wdata = '0;
    end

    always_comb begin
        data_attr.we    = dmem_wr_en_i;
        data_attr.addr  = {dmem_addr_i[31:2], 2'b00};
        data_attr.be    = 4'b1111;
        data_attr.wdata = dmem_wdata_i;
        d_misaligned    = 1'b0;
        case (dmem_byte_en_i)
            BYTE: begin
                data_attr.be    = 4'b0001 << dmem_addr_i[1:0];
                data_attr.wdata = {4{dmem_wdata_i[7:0]}};
            end
            HALF_WORD: begin
                data_attr.be    = 4'b0011 << dmem_addr_i[1:0];
                data_attr.wdata = {2{dmem_wdata_i[15:0]}};
                d_misaligned    = dmem_addr_i[0];
            end
            WORD: begin
                d_misaligned = |dmem_addr_i[1:0];
            end
            default: begin
                d_misaligned = 1'b1;
            end
        endcase
    end

    // Misaligned data requests are answered locally and pre-empt any bus selection.
    assign streak_full = (streak_q == StreakMax);
    assign idle_err    = dmem_req_i & d_misaligned;
    assign idle_fetch  = ~idle_err & imem_req_i & (~dmem_req_i | streak_full);
    assign idle_data   = ~idle_err & dmem_req_i & ~idle_fetch;

    always_comb begin
        state_d       = state_q;
        owner_fetch_d = owner_fetch_q;
        attr_d        = attr_q;
        bus_req       = 1'b0;
        cur_fetch     = owner_fetch_q;
        resp          = 1'b0;
        err           = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (idle_err) begin
                    err = 1'b1;
                end else if (idle_fetch || idle_data) begin
                    bus_req       = 1'b1;
                    cur_fetch     = idle_fetch;
                    owner_fetch_d = idle_fetch;
                    attr_d        = idle_fetch ? fetch_attr : data_attr;
                    state_d       = bus_gnt_i ? StResp : StReq;
                end
            end
            StReq: begin
                bus_req = 1'b1;
                if (bus_gnt_i) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (bus_rvalid_i) begin
                    resp    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus_take = bus_req & bus_gnt_i;

    always_comb begin
        streak_d = streak_q;
        if (!imem_req_i || (bus_take && cur_fetch)) begin
            streak_d = '0;
        end else if (bus_take && !cur_fetch && !streak_full) begin
            streak_d = streak_q + StreakW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            owner_fetch_q <= 1'b0;
            streak_q      <= '0;
            attr_q        <= '0;
        end else begin
            state_q       <= state_d;
            owner_fetch_q <= owner_fetch_d;
            streak_q      <= streak_d;
            attr_q        <= attr_d;
        end
    end

    // Reset is synchronous, so outputs are forced low combinationally while it is held.
    assign bus_req_o     = ~rst & bus_req;
    assign bus_we_o      = ~rst & attr_d.we;
    assign bus_be_o      = rst ? '0 : attr_d.be;
    assign bus_addr_o    = rst ? '0 : attr_d.addr;
    assign bus_wdata_o   = rst ? '0 : attr_d.wdata;

    assign imem_gnt_o    = ~rst & bus_take & cur_fetch;
    assign dmem_gnt_o    = ~rst & ((bus_take & ~cur_fetch) | err);
    assign dmem_err_o    = ~rst & err;

    assign imem_rvalid_o = ~rst & resp & owner_fetch_q;
    assign dmem_rvalid_o = ~rst & resp & ~owner_fetch_q;
    assign imem_rdata_o  = imem_rvalid_o ? bus_rdata_i : '0;
    assign dmem_rdata_o  = dmem_rvalid_o ? bus_rdata_i : '0;

endmodule

// File: tb/tb_sparrow_mem_arbiter.sv
// Bench for sparrow_mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_sparrow_mem_arbiter;

    localparam int unsigned MAXD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_i;
    logic [31:0] imem_addr_i;
    logic        imem_gnt_o, imem_rvalid_o;
    logic [31:0] imem_rdata_o;
    logic        dmem_req_i, dmem_wr_en_i;
    logic [1:0]  dmem_byte_en_i;
    logic [31:0] dmem_addr_i, dmem_wdata_i;
    logic        dmem_gnt_o, dmem_rvalid_o, dmem_err_o;
    logic [31:0] dmem_rdata_o;
    logic        bus_req_o, bus_we_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic        bus_gnt_i, bus_rvalid_i;
    logic [31:0] bus_rdata_i;

    int n_vec = 0;
    int n_err = 0;

    sparrow_mem_arbiter #(.MAX_DSTREAK(MAXD)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_i    (imem_req_i),
        .imem_addr_i   (imem_addr_i),
        .imem_gnt_o    (imem_gnt_o),
        .imem_rvalid_o (imem_rvalid_o),
        .imem_rdata_o  (imem_rdata_o),
        .dmem_req_i    (dmem_req_i),
        .dmem_wr_en_i  (dmem_wr_en_i),
        .dmem_byte_en_i(dmem_byte_en_i),
        .dmem_addr_i   (dmem_addr_i),
        .dmem_wdata_i  (dmem_wdata_i),
        .dmem_gnt_o    (dmem_gnt_o),
        .dmem_rvalid_o (dmem_rvalid_o),
        .dmem_rdata_o  (dmem_rdata_o),
        .dmem_err_o    (dmem_err_o),
        .bus_req_o     (bus_req_o),
        .bus_we_o      (bus_we_o),
        .bus_be_o      (bus_be_o),
        .bus_addr_o    (bus_addr_o),
        .bus_wdata_o   (bus_wdata_o),
        .bus_gnt_i     (bus_gnt_i),
        .bus_rvalid_i  (bus_rvalid_i),
        .bus_rdata_i   (bus_rdata_i)
    );

    always #5 clk = ~clk;

    // Reference rules for a data access, stated as plain arithmetic.
    function automatic bit is_misaligned(input logic [1:0] size, input logic [31:0] addr);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return (addr % 2) != 0;
            2'b11:   return (addr % 4) != 0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lanes(input logic [1:0] size, input logic [31:0] addr);
        int off;
        off = int'(addr % 4);
        case (size)
            2'b00:   return 4'(1 << off);
            2'b01:   return 4'(3 << off);
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] spread(input logic [1:0] size, input logic [31:0] w);
        case (size)
            2'b00:   return (w % 256) * 32'h0101_0101;
            2'b01:   return (w % 65536) * 32'h0001_0001;
            default: return w;
        endcase
    endfunction

    task automatic clear_inputs();
        imem_req_i     = 1'b0;
        imem_addr_i    = '0;
        dmem_req_i     = 1'b0;
        dmem_wr_en_i   = 1'b0;
        dmem_byte_en_i = 2'b00;
        dmem_addr_i    = '0;
        dmem_wdata_i   = '0;
        bus_gnt_i      = 1'b0;
        bus_rvalid_i   = 1'b0;
        bus_rdata_i    = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic drain();
        clear_inputs();
        bus_gnt_i    = 1'b1;
        bus_rvalid_i = 1'b1;
        repeat (3) cyc();
        clear_inputs();
        cyc();
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        imem_req_i   = 1'b1;
        imem_addr_i  = 32'h0000_0040;
        dmem_req_i   = 1'b1;
        dmem_wr_en_i = 1'b1;
        dmem_addr_i  = 32'h0000_0080;
        dmem_wdata_i = 32'h1234_5678;
        bus_gnt_i    = 1'b1;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'hCAFE_F00D;
        cyc();
        settle();
        n_vec++;
        if ({bus_req_o, imem_gnt_o, dmem_gnt_o, dmem_err_o, imem_rvalid_o, dmem_rvalid_o}
            !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {bus_req_o, imem_gnt_o, dmem_gnt_o, dmem_err_o, imem_rvalid_o, dmem_rvalid_o});
        end
        n_vec++;
        if ({bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o, imem_rdata_o, dmem_rdata_o} !== 133'd0) begin
            n_err++;
            $display("FAIL reset_data: got addr %h be %b wdata %h expected all zero",
                     bus_addr_o, bus_be_o, bus_wdata_o);
        end
        cyc();
        rst = 1'b0;
        clear_inputs();
        settle();
        n_vec++;
        if ({bus_req_o, imem_gnt_o, dmem_gnt_o, dmem_err_o, imem_rvalid_o, dmem_rvalid_o,
             bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o, imem_rdata_o, dmem_rdata_o} !== 139'd0) begin
            n_err++;
            $display("FAIL post_reset: got addr %h be %b wdata %h req %b expected all zero",
                     bus_addr_o, bus_be_o, bus_wdata_o, bus_req_o);
        end
        cyc();
    endtask

    task automatic test_fetch_only();
        imem_req_i  = 1'b1;
        imem_addr_i = 32'h0000_0104;
        bus_gnt_i   = 1'b1;
        settle();
        n_vec++;
        if ({bus_req_o, imem_gnt_o, dmem_gnt_o, bus_we_o, bus_be_o, bus_addr_o}
            !== {4'b1100, 4'b1111, 32'h0000_0104}) begin
            n_err++;
            $display("FAIL fetch_issue: got req/ig/dg/we %b be %b addr %h expected 1100 1111 00000104",
                     {bus_req_o, imem_gnt_o, dmem_gnt_o, bus_we_o}, bus_be_o, bus_addr_o);
        end
        cyc();
        imem_req_i = 1'b0;
        bus_gnt_i  = 1'b0;
        settle();
        n_vec++;
        if ({bus_req_o, imem_rvalid_o} !== 2'b00) begin
            n_err++;
            $display("FAIL fetch_wait: got req/rv %b expected 00", {bus_req_o, imem_rvalid_o});
        end
        cyc();
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'hDEAD_BEEF;
        settle();
        n_vec++;
        if ({imem_rvalid_o, dmem_rvalid_o, imem_rdata_o} !== {2'b10, 32'hDEAD_BEEF}) begin
            n_err++;
            $display("FAIL fetch_resp: got rv %b rdata %h expected 10 deadbeef",
                     {imem_rvalid_o, dmem_rvalid_o}, imem_rdata_o);
        end
        cyc();
        bus_rvalid_i = 1'b0;
        settle();
        n_vec++;
        if (imem_rvalid_o !== 1'b0) begin
            n_err++;
            $display("FAIL fetch_resp_once: got rvalid %b expected 0", imem_rvalid_o);
        end
        cyc();
        clear_inputs();
    endtask

    task automatic test_stores();
        dmem_req_i     = 1'b1;
        dmem_wr_en_i   = 1'b1;
        dmem_byte_en_i = 2'b00;
        dmem_addr_i    = 32'h0000_0203;
        dmem_wdata_i   = 32'h0000_00AB;
        bus_gnt_i      = 1'b1;
        settle();
        n_vec++;
        if ({bus_req_o, dmem_gnt_o, dmem_err_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o}
            !== {4'b1101, 4'b1000, 32'h0000_0200, 32'hABAB_ABAB}) begin
            n_err++;
            $display("FAIL byte_store: got be %b addr %h wdata %h we %b expected 1000 00000200 abababab 1",
                     bus_be_o, bus_addr_o, bus_wdata_o, bus_we_o);
        end
        cyc();
        clear_inputs();
        cyc();
        bus_rvalid_i = 1'b1;
        settle();
        n_vec++;
        if ({dmem_rvalid_o, imem_rvalid_o} !== 2'b10) begin
            n_err++;
            $display("FAIL byte_store_resp: got d/i rvalid %b expected 10", {dmem_rvalid_o, imem_rvalid_o});
        end
        cyc();
        clear_inputs();
        dmem_req_i     = 1'b1;
        dmem_wr_en_i   = 1'b1;
        dmem_byte_en_i = 2'b01;
        dmem_addr_i    = 32'h0000_0102;
        dmem_wdata_i   = 32'hFFFF_1234;
        bus_gnt_i      = 1'b1;
        settle();
        n_vec++;
        if ({bus_be_o, bus_addr_o, bus_wdata_o} !== {4'b1100, 32'h0000_0100, 32'h1234_1234}) begin
            n_err++;
            $display("FAIL half_store: got be %b addr %h wdata %h expected 1100 00000100 12341234",
                     bus_be_o, bus_addr_o, bus_wdata_o);
        end
        cyc();
        drain();
    endtask

    task automatic test_starvation();
        bit exp_fetch [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        int g = 0;
        imem_req_i     = 1'b1;
        imem_addr_i    = 32'h0000_0600;
        dmem_req_i     = 1'b1;
        dmem_byte_en_i = 2'b11;
        dmem_addr_i    = 32'h0000_0700;
        bus_gnt_i      = 1'b1;
        bus_rvalid_i   = 1'b1;
        for (int c = 0; c < 20; c++) begin
            settle();
            if (imem_gnt_o === 1'b1 || dmem_gnt_o === 1'b1) begin
                n_vec++;
                if (g >= 10 || imem_gnt_o !== exp_fetch[g] || dmem_gnt_o !== !exp_fetch[g]) begin
                    n_err++;
                    $display("FAIL starve_order: grant %0d got i/d %b%b expected fetch=%0d",
                             g, imem_gnt_o, dmem_gnt_o, (g < 10) ? int'(exp_fetch[g]) : -1);
                end
                g++;
            end
            cyc();
        end
        n_vec++;
        if (g != 10) begin
            n_err++;
            $display("FAIL starve_count: got %0d grants expected 10", g);
        end
        drain();
    endtask

    task automatic test_misaligned();
        imem_req_i     = 1'b1;
        imem_addr_i    = 32'h0000_0300;
        dmem_req_i     = 1'b1;
        dmem_byte_en_i = 2'b11;
        dmem_addr_i    = 32'h0000_0102;
        bus_gnt_i      = 1'b1;
        settle();
        n_vec++;
        if ({dmem_gnt_o, dmem_err_o, bus_req_o, imem_gnt_o} !== 4'b1100) begin
            n_err++;
            $display("FAIL misaligned_err: got dg/err/req/ig %b expected 1100",
                     {dmem_gnt_o, dmem_err_o, bus_req_o, imem_gnt_o});
        end
        cyc();
        dmem_req_i = 1'b0;
        settle();
        n_vec++;
        if ({imem_gnt_o, bus_req_o, dmem_err_o, dmem_gnt_o, bus_addr_o} !== {4'b1100, 32'h0000_0300}) begin
            n_err++;
            $display("FAIL misaligned_next_fetch: got ig/req/err/dg %b addr %h expected 1100 00000300",
                     {imem_gnt_o, bus_req_o, dmem_err_o, dmem_gnt_o}, bus_addr_o);
        end
        cyc();
        drain();
    endtask

    task automatic test_bus_stall();
        imem_req_i  = 1'b1;
        imem_addr_i = 32'h0000_0400;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                dmem_req_i     = 1'b1;
                dmem_byte_en_i = 2'b11;
                dmem_addr_i    = 32'h0000_0500;
            end
            settle();
            n_vec++;
            if ({bus_req_o, imem_gnt_o, dmem_gnt_o, bus_we_o, bus_be_o, bus_addr_o}
                !== {4'b1000, 4'b1111, 32'h0000_0400}) begin
                n_err++;
                $display("FAIL stall_hold: cycle %0d got req/ig/dg/we %b be %b addr %h expected 1000 1111 00000400",
                         c, {bus_req_o, imem_gnt_o, dmem_gnt_o, bus_we_o}, bus_be_o, bus_addr_o);
            end
            cyc();
        end
        bus_gnt_i = 1'b1;
        settle();
        n_vec++;
        if ({imem_gnt_o, dmem_gnt_o, bus_addr_o} !== {2'b10, 32'h0000_0400}) begin
            n_err++;
            $display("FAIL stall_release: got ig/dg %b addr %h expected 10 00000400",
                     {imem_gnt_o, dmem_gnt_o}, bus_addr_o);
        end
        cyc();
        imem_req_i = 1'b0;
        settle();
        n_vec++;
        if ({bus_req_o, dmem_gnt_o} !== 2'b00) begin
            n_err++;
            $display("FAIL stall_resp_wait: got req/dg %b expected 00", {bus_req_o, dmem_gnt_o});
        end
        cyc();
        bus_rvalid_i = 1'b1;
        settle();
        n_vec++;
        if ({imem_rvalid_o, dmem_gnt_o} !== 2'b10) begin
            n_err++;
            $display("FAIL stall_resp: got irv/dg %b expected 10", {imem_rvalid_o, dmem_gnt_o});
        end
        cyc();
        bus_rvalid_i = 1'b0;
        settle();
        n_vec++;
        if ({dmem_gnt_o, bus_req_o, bus_addr_o} !== {2'b11, 32'h0000_0500}) begin
            n_err++;
            $display("FAIL stall_data_after: got dg/req %b addr %h expected 11 00000500",
                     {dmem_gnt_o, bus_req_o}, bus_addr_o);
        end
        cyc();
        drain();
    endtask

    task automatic test_reset_in_resp();
        imem_req_i  = 1'b1;
        imem_addr_i = 32'h0000_0800;
        bus_gnt_i   = 1'b1;
        cyc();
        rst          = 1'b1;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'h5555_AAAA;
        settle();
        n_vec++;
        if ({bus_req_o, imem_gnt_o, dmem_gnt_o, dmem_err_o, imem_rvalid_o, dmem_rvalid_o,
             bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o, imem_rdata_o, dmem_rdata_o} !== 139'd0) begin
            n_err++;
            $display("FAIL rst_in_resp: got req %b irv %b addr %h rdata %h expected all zero",
                     bus_req_o, imem_rvalid_o, bus_addr_o, imem_rdata_o);
        end
        cyc();
        rst        = 1'b0;
        imem_req_i = 1'b0;
        bus_gnt_i  = 1'b0;
        settle();
        n_vec++;
        if ({imem_rvalid_o, dmem_rvalid_o, bus_req_o} !== 3'b000) begin
            n_err++;
            $display("FAIL rst_drop_resp: got irv/drv/req %b expected 000",
                     {imem_rvalid_o, dmem_rvalid_o, bus_req_o});
        end
        cyc();
        clear_inputs();
        cyc();
    endtask

    task automatic test_random();
        int           m_phase = 0;  // 0 idle, 1 waiting for bus grant, 2 waiting for response
        int           m_streak = 0;
        bit           m_fetch = 0;
        logic [31:0]  m_addr = '0, m_wdata = '0;
        logic [3:0]   m_be = '0;
        logic         m_we = 1'b0;
        bit           i_pend = 0, d_pend = 0;
        logic [31:0]  i_addr = '0, d_addr = '0, d_wdata = '0;
        logic [1:0]   d_size = '0;
        logic         d_we = 1'b0;
        logic         e_breq, e_igt, e_dgt, e_err, e_irv, e_drv, e_fetch, e_we;
        logic [31:0]  e_addr, e_wdata;
        logic [3:0]   e_be;

        rst = 1'b1;
        clear_inputs();
        cyc();
        rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (!i_pend && $urandom_range(0, 9) < 7) begin
                i_pend = 1;
                i_addr = $urandom;
            end
            if (!d_pend && $urandom_range(0, 9) < 7) begin
                d_pend  = 1;
                d_size  = 2'($urandom_range(0, 3));
                d_addr  = $urandom;
                d_we    = 1'($urandom_range(0, 1));
                d_wdata = $urandom;
                if ($urandom_range(0, 3) != 0) begin
                    if (d_size == 2'b01) d_addr = d_addr & ~32'h1;
                    if (d_size == 2'b11) d_addr = d_addr & ~32'h3;
                end
            end
            imem_req_i     = i_pend;
            imem_addr_i    = i_addr;
            dmem_req_i     = d_pend;
            dmem_byte_en_i = d_size;
            dmem_addr_i    = d_addr;
            dmem_wr_en_i   = d_we;
            dmem_wdata_i   = d_wdata;
            bus_gnt_i      = ($urandom_range(0, 9) < 6);
            bus_rvalid_i   = 1'($urandom_range(0, 1));
            bus_rdata_i    = $urandom;
            settle();

            e_breq = 0; e_igt = 0; e_dgt = 0; e_err = 0; e_irv = 0; e_drv = 0;
            e_fetch = m_fetch; e_addr = m_addr; e_be = m_be; e_we = m_we; e_wdata = m_wdata;
            if (!rst) begin
                if (m_phase == 0) begin
                    if (d_pend && is_misaligned(d_size, d_addr)) begin
                        e_dgt = 1;
                        e_err = 1;
                    end else if (i_pend || d_pend) begin
                        e_breq  = 1;
                        e_fetch = i_pend && (!d_pend || m_streak == MAXD);
                        if (e_fetch) begin
                            e_addr = i_addr & ~32'h3; e_be = 4'hF; e_we = 0; e_wdata = '0;
                        end else begin
                            e_addr  = d_addr & ~32'h3;
                            e_be    = lanes(d_size, d_addr);
                            e_we    = d_we;
                            e_wdata = spread(d_size, d_wdata);
                        end
                    end
                end else if (m_phase == 1) begin
                    e_breq = 1;
                end else if (bus_rvalid_i) begin
                    e_irv = m_fetch;
                    e_drv = !m_fetch;
                end
                if (e_breq && bus_gnt_i) begin
                    e_igt = e_fetch;
                    e_dgt = !e_fetch;
                end
            end

            n_vec++;
            if ({bus_req_o, imem_gnt_o, dmem_gnt_o, dmem_err_o} !== {e_breq, e_igt, e_dgt, e_err}) begin
                n_err++;
                $display("FAIL rnd_handshake: cycle %0d got req/ig/dg/err %b expected %b", c,
                         {bus_req_o, imem_gnt_o, dmem_gnt_o, dmem_err_o}, {e_breq, e_igt, e_dgt, e_err});
            end
            n_vec++;
            if ({imem_rvalid_o, dmem_rvalid_o} !== {e_irv, e_drv}) begin
                n_err++;
                $display("FAIL rnd_rvalid: cycle %0d got i/d %b expected %b", c,
                         {imem_rvalid_o, dmem_rvalid_o}, {e_irv, e_drv});
            end
            if (e_breq) begin
                n_vec++;
                if ({bus_addr_o, bus_be_o, bus_we_o} !== {e_addr, e_be, e_we}) begin
                    n_err++;
                    $display("FAIL rnd_attr: cycle %0d got addr %h be %b we %b expected %h %b %b", c,
                             bus_addr_o, bus_be_o, bus_we_o, e_addr, e_be, e_we);
                end
                if (!e_fetch) begin
                    n_vec++;
                    if (bus_wdata_o !== e_wdata) begin
                        n_err++;
                        $display("FAIL rnd_wdata: cycle %0d got %h expected %h", c, bus_wdata_o, e_wdata);
                    end
                end
            end
            if (e_irv || e_drv) begin
                n_vec++;
                if ((e_irv ? imem_rdata_o : dmem_rdata_o) !== bus_rdata_i) begin
                    n_err++;
                    $display("FAIL rnd_rdata: cycle %0d got %h expected %h", c,
                             e_irv ? imem_rdata_o : dmem_rdata_o, bus_rdata_i);
                end
            end
            if (rst) begin
                n_vec++;
                if ({bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o, imem_rdata_o, dmem_rdata_o} !== 133'd0) begin
                    n_err++;
                    $display("FAIL rnd_rst_data: cycle %0d got addr %h wdata %h expected zero", c,
                             bus_addr_o, bus_wdata_o);
                end
            end

            if (rst) begin
                m_phase = 0; m_streak = 0; m_fetch = 0;
                m_addr = '0; m_be = '0; m_we = 0; m_wdata = '0;
            end else begin
                if (!i_pend || e_igt) m_streak = 0;
                else if (e_dgt && !e_err && m_streak < MAXD) m_streak++;
                case (m_phase)
                    0: if (e_breq) begin
                        m_phase = bus_gnt_i ? 2 : 1;
                        m_fetch = e_fetch; m_addr = e_addr; m_be = e_be; m_we = e_we; m_wdata = e_wdata;
                    end
                    1: if (bus_gnt_i) m_phase = 2;
                    default: if (bus_rvalid_i) m_phase = 0;
                endcase
            end
            if (e_igt) i_pend = 0;
            if (e_dgt) d_pend = 0;
            cyc();
        end
        rst = 1'b0;
        clear_inputs();
        cyc();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        #1;
        test_reset();
        test_fetch_only();
        test_stores();
        test_starvation();
        test_misaligned();
        test_bus_stall();
        test_reset_in_resp();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
